// File: rtl/cpu_sequencer_fsm_if.sv
// Control bundle between the CPU sequencer and its datapath: the instruction
// and status words flow in, every datapath strobe and select flows out.
interface cpu_sequencer_fsm_if;
  logic [15:0] IRout;
  logic [2:0]  status;
  logic        pc_reset;
  logic        loadPC;
  logic        loadIR;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        write;
  logic        mwrite;
  logic        load_addr;
  logic        msel;
  logic        asel;
  logic        bsel;
  logic [3:0]  vsel;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [1:0]  shiftinput;
  logic [1:0]  ALUop;
  logic [15:0] sximm5;
  logic [15:0] sximm8;
  logic        halted;

  modport master (
    input  IRout, status,
    output pc_reset, loadPC, loadIR, loada, loadb, loadc, loads, write, mwrite,
           load_addr, msel, asel, bsel, vsel, readnum, writenum, shiftinput,
           ALUop, sximm5, sximm8, halted
  );

  modport slave (
    output IRout, status,
    input  pc_reset, loadPC, loadIR, loada, loadb, loadc, loads, write, mwrite,
           load_addr, msel, asel, bsel, vsel, readnum, writenum, shiftinput,
           ALUop, sximm5, sximm8, halted
  );
endinterface

// File: rtl/cpu_sequencer_fsm.sv
// Moore sequencer for the CPU datapath: fetch (PC->mem->IR->PC+1), decode and
// execute of MOV/ADD/CMP/AND/MVN/LDR/STR/HALT. Memory waits dwell MEM_LAT cycles.
module cpu_sequencer_fsm #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  cpu_sequencer_fsm_if.master bus
);

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WIMM, S_GETA, S_GETB, S_EXEC,
    S_WRC, S_ADDR, S_LADR, S_MEM, S_WRM, S_GETD, S_PASS, S_STR, S_HALT
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_cnt;

  logic [2:0] w_opcode, w_rn, w_rd, w_rm;
  logic [1:0] w_op, w_sh;
  logic       w_movi, w_movr, w_alu, w_cmp, w_mvn, w_ldr, w_str;
  logic       w_unused_status;

  assign w_opcode = bus.IRout[15:13];
  assign w_op     = bus.IRout[12:11];
  assign w_rn     = bus.IRout[10:8];
  assign w_rd     = bus.IRout[7:5];
  assign w_sh     = bus.IRout[4:3];
  assign w_rm     = bus.IRout[2:0];

  assign w_movi = (w_opcode == 3'b110) && (w_op == 2'b10);
  assign w_movr = (w_opcode == 3'b110) && (w_op == 2'b00);
  assign w_alu  = (w_opcode == 3'b101) && ((w_op == 2'b00) || (w_op == 2'b10));
  assign w_cmp  = (w_opcode == 3'b101) && (w_op == 2'b01);
  assign w_mvn  = (w_opcode == 3'b101) && (w_op == 2'b11);
  assign w_ldr  = (w_opcode == 3'b011) && (w_op == 2'b00);
  assign w_str  = (w_opcode == 3'b100) && (w_op == 2'b00);

  // Status flags are observed only; this ISA has no conditional sequencing.
  assign w_unused_status = ^bus.status;

  assign bus.sximm5 = {{11{bus.IRout[4]}}, bus.IRout[4:0]};
  assign bus.sximm8 = {{8{bus.IRout[7]}}, bus.IRout[7:0]};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_RST;
    else        r_state <= w_next;
  end

  // Dwell counter: reloads on entry to a memory-wait state, counts down to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (((w_next == S_IF1) && (r_state != S_IF1)) ||
                 ((w_next == S_MEM) && (r_state != S_MEM))) begin
      r_cnt <= 3'(MEM_LAT - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    w_next         = r_state;
    bus.pc_reset   = 1'b0;
    bus.loadPC     = 1'b0;
    bus.loadIR     = 1'b0;
    bus.loada      = 1'b0;
    bus.loadb      = 1'b0;
    bus.loadc      = 1'b0;
    bus.loads      = 1'b0;
    bus.write      = 1'b0;
    bus.mwrite     = 1'b0;
    bus.load_addr  = 1'b0;
    bus.msel       = 1'b0;
    bus.asel       = 1'b0;
    bus.bsel       = 1'b0;
    bus.vsel       = 4'b0001;
    bus.readnum    = '0;
    bus.writenum   = '0;
    bus.shiftinput = '0;
    bus.ALUop      = '0;
    bus.halted     = 1'b0;
    unique case (r_state)
      S_RST: begin
        bus.pc_reset = 1'b1;
        bus.loadPC   = 1'b1;
        bus.vsel     = '0;
        w_next       = S_IF1;
      end
      S_IF1:  if (r_cnt == '0) w_next = S_IF2;
      S_IF2:  begin bus.loadIR = 1'b1; w_next = S_UPC; end
      S_UPC:  begin bus.loadPC = 1'b1; w_next = S_DEC; end
      S_DEC: begin
        if (w_movi)                              w_next = S_WIMM;
        else if (w_movr || w_mvn)                w_next = S_GETB;
        else if (w_alu || w_cmp || w_ldr || w_str) w_next = S_GETA;
        else                                     w_next = S_HALT;
      end
      S_WIMM: begin
        bus.writenum = w_rn;
        bus.vsel     = 4'b0100;
        bus.write    = 1'b1;
        w_next       = S_IF1;
      end
      S_GETA: begin
        bus.readnum = w_rn;
        bus.loada   = 1'b1;
        w_next      = (w_ldr || w_str) ? S_ADDR : S_GETB;
      end
      S_GETB: begin
        bus.readnum = w_rm;
        bus.loadb   = 1'b1;
        w_next      = S_EXEC;
      end
      S_EXEC: begin
        bus.shiftinput = w_sh;
        bus.asel       = w_movr;
        bus.ALUop      = (w_opcode == 3'b101) ? w_op : 2'b00;
        if (w_cmp) begin
          bus.loads = 1'b1;
          w_next    = S_IF1;
        end else begin
          bus.loadc = 1'b1;
          w_next    = S_WRC;
        end
      end
      S_WRC: begin
        bus.writenum = w_rd;
        bus.write    = 1'b1;
        w_next       = S_IF1;
      end
      S_ADDR: begin
        bus.bsel  = 1'b1;
        bus.loadc = 1'b1;
        w_next    = S_LADR;
      end
      S_LADR: begin
        bus.load_addr = 1'b1;
        w_next        = w_ldr ? S_MEM : S_GETD;
      end
      S_MEM: begin
        bus.msel = 1'b1;
        if (r_cnt == '0) w_next = S_WRM;
      end
      S_WRM: begin
        bus.writenum = w_rd;
        bus.vsel     = 4'b1000;
        bus.write    = 1'b1;
        w_next       = S_IF1;
      end
      S_GETD: begin
        bus.readnum = w_rd;
        bus.loadb   = 1'b1;
        w_next      = S_PASS;
      end
      S_PASS: begin
        bus.asel  = 1'b1;
        bus.loadc = 1'b1;
        w_next    = S_STR;
      end
      S_STR: begin
        bus.msel   = 1'b1;
        bus.mwrite = 1'b1;
        w_next     = S_IF1;
      end
      S_HALT:  bus.halted = 1'b1;
      default: w_next = S_RST;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer_fsm.sv
// Bench for cpu_sequencer_fsm: acts as the datapath (loads IRout when the
// sequencer strobes loadIR), queues the expected per-cycle control word for
// each issued instruction, and a negedge monitor pops and compares.
module tb_cpu_sequencer_fsm;
  localparam int unsigned MEM_LAT = 3;
  localparam int unsigned HALT_CYC = 20;

  typedef struct packed {
    logic       pc_reset, loadPC, loadIR, loada, loadb, loadc, loads, write;
    logic       mwrite, load_addr, msel, asel, bsel, halted;
    logic [3:0] vsel;
    logic [2:0] readnum, writenum;
    logic [1:0] shiftinput, ALUop;
  } ctl_t;

  typedef struct {
    ctl_t  c;
    string nm;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  bit   mon_en = 1'b0;
  int unsigned errors = 0;
  int unsigned checks = 0;
  rec_t exp_q[$];
  logic [15:0] prog_q[$];

  cpu_sequencer_fsm_if bus();

  cpu_sequencer_fsm #(.MEM_LAT(MEM_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic ctl_t nominal();
    ctl_t c;
    c = '0;
    c.vsel = 4'b0001;
    return c;
  endfunction

  function automatic ctl_t sample();
    ctl_t c;
    c.pc_reset = bus.pc_reset;   c.loadPC = bus.loadPC;   c.loadIR = bus.loadIR;
    c.loada = bus.loada;         c.loadb = bus.loadb;     c.loadc = bus.loadc;
    c.loads = bus.loads;         c.write = bus.write;     c.mwrite = bus.mwrite;
    c.load_addr = bus.load_addr; c.msel = bus.msel;       c.asel = bus.asel;
    c.bsel = bus.bsel;           c.halted = bus.halted;   c.vsel = bus.vsel;
    c.readnum = bus.readnum;     c.writenum = bus.writenum;
    c.shiftinput = bus.shiftinput; c.ALUop = bus.ALUop;
    return c;
  endfunction

  task automatic push(input ctl_t c, input string nm);
    rec_t r;
    r.c = c;
    r.nm = nm;
    exp_q.push_back(r);
  endtask

  task automatic push_fetch();
    ctl_t c;
    for (int unsigned i = 0; i < MEM_LAT; i++) push(nominal(), "IF1");
    c = nominal(); c.loadIR = 1'b1; push(c, "IF2");
  endtask

  task automatic push_read(input logic [2:0] r, input bit to_a, input string nm);
    ctl_t c;
    c = nominal(); c.readnum = r;
    if (to_a) c.loada = 1'b1; else c.loadb = 1'b1;
    push(c, nm);
  endtask

  task automatic push_wr(input logic [2:0] r, input logic [3:0] v, input string nm);
    ctl_t c;
    c = nominal(); c.writenum = r; c.vsel = v; c.write = 1'b1;
    push(c, nm);
  endtask

  // Expected control sequence of one instruction, from UPC to its last cycle,
  // followed by the next fetch (or the halt dwell).
  task automatic push_instr(input logic [15:0] ir, output bit is_halt);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    ctl_t c;
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8]; rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
    is_halt = 1'b0;
    c = nominal(); c.loadPC = 1'b1; push(c, "UPC");
    push(nominal(), "DEC");
    if (opc == 3'b110 && op == 2'b10) begin
      push_wr(rn, 4'b0100, "WIMM");
    end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
      if (opc == 3'b101 && op != 2'b11) push_read(rn, 1'b1, "GETA");
      push_read(rm, 1'b0, "GETB");
      c = nominal(); c.shiftinput = sh;
      c.asel = (opc == 3'b110);
      c.ALUop = (opc == 3'b101) ? op : 2'b00;
      if (opc == 3'b101 && op == 2'b01) c.loads = 1'b1; else c.loadc = 1'b1;
      push(c, "EXEC");
      if (!(opc == 3'b101 && op == 2'b01)) push_wr(rd, 4'b0001, "WRC");
    end else if ((opc == 3'b011 || opc == 3'b100) && op == 2'b00) begin
      push_read(rn, 1'b1, "GETA");
      c = nominal(); c.bsel = 1'b1; c.loadc = 1'b1; push(c, "ADDR");
      c = nominal(); c.load_addr = 1'b1; push(c, "LADR");
      if (opc == 3'b011) begin
        for (int unsigned i = 0; i < MEM_LAT; i++) begin
          c = nominal(); c.msel = 1'b1; push(c, "MEM");
        end
        push_wr(rd, 4'b1000, "WRM");
      end else begin
        push_read(rd, 1'b0, "GETD");
        c = nominal(); c.asel = 1'b1; c.loadc = 1'b1; push(c, "PASS");
        c = nominal(); c.msel = 1'b1; c.mwrite = 1'b1; push(c, "STR");
      end
    end else begin
      is_halt = 1'b1;
      for (int unsigned i = 0; i < HALT_CYC; i++) begin
        c = nominal(); c.halted = 1'b1; push(c, "HALT");
      end
    end
    if (!is_halt) push_fetch();
  endtask

  // Called #1 after a posedge: reset falls now, held for 'hold' rising edges.
  task automatic apply_reset(input int unsigned hold);
    ctl_t c;
    exp_q.delete();
    reset = 1'b0;
    c = '0; c.pc_reset = 1'b1; c.loadPC = 1'b1;
    for (int unsigned i = 0; i <= hold; i++) push(c, "RST");
    mon_en = 1'b1;
    repeat (hold) @(posedge clk);
    #1 reset = 1'b1;
    push_fetch();
  endtask

  task automatic wait_loadir();
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!bus.loadIR && n < 100);
    if (!bus.loadIR) begin
      $display("FAIL loadIR_timeout: no loadIR within %0d cycles (need 1)", n);
      $fatal(1, "sequencer stalled");
    end
  endtask

  task automatic issue(input logic [15:0] ir, output bit is_halt);
    @(posedge clk); #1;
    bus.IRout = ir;
    bus.status = 3'($urandom);
    push_instr(ir, is_halt);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL drain_timeout: %0d expected cycles left (need 0)", exp_q.size());
      $fatal(1, "scoreboard not drained");
    end
    mon_en = 1'b0;
  endtask

  task automatic run_prog();
    bit h;
    h = 1'b0;
    foreach (prog_q[i]) begin
      wait_loadir();
      issue(prog_q[i], h);
      if (h) break;
    end
    drain();
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] ir;
    ir = 16'($urandom);
    case ($urandom_range(0, 7))
      0:       ir[15:11] = 5'b11010;
      1:       ir[15:11] = 5'b11000;
      2:       ir[15:11] = 5'b10100;
      3:       ir[15:11] = 5'b10101;
      4:       ir[15:11] = 5'b10110;
      5:       ir[15:11] = 5'b10111;
      6:       ir[15:11] = 5'b01100;
      default: ir[15:11] = 5'b10000;
    endcase
    return ir;
  endfunction

  // Monitor: one control word per cycle, compared against the scoreboard head.
  always @(negedge clk) begin
    ctl_t act;
    rec_t e;
    logic [15:0] ir;
    if (mon_en) begin
      act = sample();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underflow: DUT ctl=%h with no expected cycle queued", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e.c) begin
          errors++;
          $display("FAIL ctl[%s] t=%0t got=%h want=%h", e.nm, $time, act, e.c);
        end
      end
      ir = bus.IRout;
      checks++;
      if (bus.sximm5 !== {{11{ir[4]}}, ir[4:0]} || bus.sximm8 !== {{8{ir[7]}}, ir[7:0]}) begin
        errors++;
        $display("FAIL sximm IR=%h got5=%h got8=%h want5=%h want8=%h", ir, bus.sximm5,
                 bus.sximm8, {{11{ir[4]}}, ir[4:0]}, {{8{ir[7]}}, ir[7:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    bus.IRout = '0;
    bus.status = '0;
    @(posedge clk); #1;
    apply_reset(3);

    // Directed instructions, a random stream, then HALT.
    prog_q = '{16'hD3FE, 16'hA148, 16'hA900, 16'h819F, 16'h6143, 16'hC0AA, 16'hB827, 16'hB2F1};
    for (int unsigned i = 0; i < 40; i++) prog_q.push_back(rand_instr());
    prog_q.push_back(16'hE000);
    run_prog();

    // Reset pulled while the sequencer is in EXEC of an ADD.
    @(posedge clk); #1;
    apply_reset(3);
    wait_loadir();
    issue(16'hA148, h);
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    apply_reset(3);

    // Recovery, then an undefined opcode must also halt.
    prog_q = '{16'hD3FE, 16'h2000};
    run_prog();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
